// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, Hamming(7,4) framing
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             clock enable; low freezes the block and silences pulses
//   req, req_data   per-requester request level and 4-bit nibble (bits [4i+3:4i])
//   gnt, done, err  one-cycle pulses: grant, frame complete, timeout abort
//   tx_start        launch request to the transmitter, tx_data its 7-bit codeword
//   tx_busy         transmitter busy
//   state_out       IDLE=00 START=01 SEND=10 GAP=11
//   owner           index of the last-granted requester
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic                   tx_start,
    output logic [6:0]             tx_data,
    input  logic                   tx_busy,
    output logic [1:0]             state_out,
    output logic [2:0]             owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, SEND = 2'b10, GAP = 2'b11} state_t;
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t               state, state_nx;
    logic [7:0]           tcnt, tcnt_nx;
    logic [GW-1:0]        gcnt, gcnt_nx;
    logic [2:0]           owner_nx, win;
    logic [6:0]           data_nx;
    logic                 start_nx, err_r, err_nx, tmo;
    logic [NUM_REQ-1:0]   gnt_r, gnt_nx, done_r, done_nx, rot;
    int                   off;

    function automatic logic [6:0] enc(input logic [3:0] n);
        return {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
    endfunction

    // Rotate requests so bit 0 is the requester just after owner; the lowest set bit wins.
    always_comb begin
        rot = NUM_REQ'({req, req} >> (int'(owner) + 1));
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = k;
        win = 3'((int'(owner) + 1 + off) % NUM_REQ);
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt + 8'd1;
        gcnt_nx  = gcnt;
        owner_nx = owner;
        data_nx  = tx_data;
        start_nx = tx_start;
        gnt_nx   = '0;
        done_nx  = '0;
        err_nx   = 1'b0;
        tmo      = tcnt == 8'(TIMEOUT - 1);
        case (state)
            IDLE: begin
                tcnt_nx = '0;
                if (|req) begin
                    state_nx = START;
                    owner_nx = win;
                    data_nx  = enc(4'(req_data >> (4 * int'(win))));
                    gnt_nx   = NUM_REQ'(1) << win;
                    start_nx = 1'b1;
                end
            end
            START, SEND: begin
                if (state == START ? tx_busy : !tx_busy) begin
                    state_nx = state == START ? SEND : POST;
                    start_nx = 1'b0;
                    tcnt_nx  = '0;
                    gcnt_nx  = GW'(GAP_CYCLES);
                    done_nx  = state == SEND ? NUM_REQ'(1) << owner : '0;
                end else if (tmo) begin
                    state_nx = POST;
                    start_nx = 1'b0;
                    err_nx   = 1'b1;
                    gcnt_nx  = GW'(GAP_CYCLES);
                end
            end
            default: begin
                gcnt_nx  = gcnt - GW'(1);
                state_nx = gcnt == GW'(1) ? IDLE : GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            gcnt     <= '0;
            owner    <= 3'(NUM_REQ - 1);
            tx_data  <= '0;
            tx_start <= 1'b0;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
        end else if (ena) begin
            state    <= state_nx;
            tcnt     <= tcnt_nx;
            gcnt     <= gcnt_nx;
            owner    <= owner_nx;
            tx_data  <= data_nx;
            tx_start <= start_nx;
            gnt_r    <= gnt_nx;
            done_r   <= done_nx;
            err_r    <= err_nx;
        end else begin
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
        end
    end

    // Pulses are masked while ena is low so a pulse never shows on a frozen cycle.
    assign gnt       = gnt_r & {NUM_REQ{ena}};
    assign done      = done_r & {NUM_REQ{ena}};
    assign err       = err_r & ena;
    assign state_out = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a round-robin / Hamming model
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, ena, tx_busy;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt_a, done_a, gnt_b, done_b, gnt_c, done_c;
    logic        err_a, err_b, err_c, txs_a, txs_b, txs_c;
    logic [6:0]  txd_a, txd_b, txd_c;
    logic [1:0]  st_a, st_b, st_c;
    logic [2:0]  own_a, own_b, own_c;
    int          n_tests = 0, n_fail = 0, m_owner = 3;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(8), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .req_data(req_data),
        .gnt(gnt_a), .done(done_a), .err(err_a), .tx_start(txs_a), .tx_data(txd_a),
        .tx_busy(tx_busy), .state_out(st_a), .owner(own_a));
    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .TIMEOUT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .req_data(req_data),
        .gnt(gnt_b), .done(done_b), .err(err_b), .tx_start(txs_b), .tx_data(txd_b),
        .tx_busy(tx_busy), .state_out(st_b), .owner(own_b));
    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT(255)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .req_data(req_data),
        .gnt(gnt_c), .done(done_c), .err(err_c), .tx_start(txs_c), .tx_data(txd_c),
        .tx_busy(tx_busy), .state_out(st_c), .owner(own_c));

    // Hamming code by bit position: data at positions 3,5,6,7; parity at 2^j covers positions with bit j set.
    function automatic logic [6:0] ham(input logic [3:0] n);
        int dpos[4];
        logic [7:0] c;
        dpos = '{3, 5, 6, 7};
        c = '0;
        for (int i = 0; i < 4; i++) c[3'(dpos[i])] = n[i];
        for (int j = 0; j < 3; j++)
            for (int p = 1; p < 8; p++)
                if (p != (1 << j) && ((p >> j) & 1) == 1) c[3'(1 << j)] = c[3'(1 << j)] ^ c[3'(p)];
        return c[7:1];
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] r);
        logic [3:0] v;
        v = r;
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        chk("exclusive", 32'($onehot0({|gnt_a, |done_a, err_a}) && $onehot0(gnt_a) && $onehot0(done_a)), 1);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (st_a != 2'd0 && n < 400) begin
            tick;
            n++;
        end
        chk("idle_wait", st_a, 0);
    endtask

    task automatic apply_reset;
        req = '0;
        tx_busy = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        m_owner = 3;
    endtask

    task automatic serve(input int exp, input bit keep);
        int n;
        logic [3:0] nib;
        nib = 4'(req_data >> (4 * exp));
        n = 0;
        do begin
            tick;
            n++;
        end while (gnt_a == 4'd0 && n < 30);
        chk("gnt", gnt_a, 1 << exp);
        chk("tx_data", txd_a, ham(nib));
        chk("owner", own_a, exp);
        if (!keep) req = '0;
        repeat ($urandom_range(0, 3)) begin
            tick;
            chk("start_hold", txs_a, 1);
        end
        tx_busy = 1'b1;
        tick;
        chk("send_state", st_a, 2);
        chk("start_drop", txs_a, 0);
        repeat ($urandom_range(1, 6)) tick;
        tx_busy = 1'b0;
        tick;
        chk("done", done_a, 1 << exp);
        m_owner = exp;
    endtask

    initial begin
        int n, ga, gb, gc;
        bit seen, held;
        rst_n = 1'b0; ena = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        tick;
        tick;
        chk("rst_state", {st_a, st_b, st_c}, 0);
        chk("rst_owner", {own_a, own_b, own_c}, {3'd3, 3'd3, 3'd3});
        chk("rst_pulses", {gnt_a, gnt_b, gnt_c, done_a, done_b, done_c, err_a, err_b, err_c}, 0);
        chk("rst_tx", {txs_a, txs_b, txs_c, txd_a, txd_b, txd_c}, 0);
        rst_n = 1'b1;
        tick;

        req = 4'b0010; req_data = 16'h00B0;
        tick;
        chk("single_gnt", gnt_a, 4'b0010);
        chk("single_data", txd_a, 7'h55);
        chk("single_start", {txs_a, st_a}, {1'b1, 2'd1});
        req = '0;
        tick;
        tick;
        chk("single_wait", {txs_a, st_a}, {1'b1, 2'd1});
        tx_busy = 1'b1;
        tick;
        chk("single_send", {txs_a, st_a}, {1'b0, 2'd2});
        repeat (18) tick;
        tx_busy = 1'b0;
        tick;
        chk("single_done", done_a, 4'b0010);
        n = 0;
        while (st_a == 2'd3 && n < 40) begin
            n++;
            tick;
        end
        chk("single_gap", n, 8);
        m_owner = 1;

        apply_reset;
        req = 4'hF; req_data = 16'hFB10;
        for (int k = 0; k < 5; k++) serve(rr_pick(m_owner, req), 1'b1);
        req = '0;
        wait_idle;

        req = 4'b0001;
        tick;
        chk("tmo_start_gnt", gnt_a, 1 << rr_pick(m_owner, 4'b0001));
        req = '0;
        n = 0; seen = 1'b0;
        while (!err_a && n < 400) begin
            tick;
            n++;
            seen |= |done_a;
        end
        chk("tmo_start_len", n, 255);
        chk("tmo_start_out", {seen, txs_a, st_a}, {1'b0, 1'b0, 2'd3});
        m_owner = 0;
        wait_idle;

        req = 4'b0001;
        tick;
        chk("tmo_send_gnt", gnt_a, 4'b0001);
        req = '0; tx_busy = 1'b1;
        tick;
        chk("tmo_send_state", st_a, 2);
        n = 0; seen = 1'b0;
        while (!err_a && n < 400) begin
            tick;
            n++;
            seen |= |done_a;
        end
        chk("tmo_send_len", n, 255);
        chk("tmo_send_out", {seen, st_a}, {1'b0, 2'd3});
        tx_busy = 1'b0;
        tick;
        chk("tmo_send_gap", st_a, 3);
        wait_idle;

        tx_busy = 1'b1;
        tick;
        chk("busy_in_idle", st_a, 0);
        req = 4'b1000; req_data = 16'h9000;
        tick;
        chk("busy_idle_gnt", gnt_a, 1 << rr_pick(m_owner, 4'b1000));
        chk("busy_idle_start", st_a, 1);
        req = '0;
        tick;
        chk("busy_idle_send", st_a, 2);
        tx_busy = 1'b0;
        tick;
        chk("busy_idle_done", done_a, 4'b1000);
        m_owner = 3;
        req = 4'b0100;
        tick;
        tick;
        req = '0;
        wait_idle;
        req = 4'b0011; req_data = 16'h0054;
        tick;
        chk("dropped_req", gnt_a, 1 << rr_pick(m_owner, 4'b0011));
        req = '0; tx_busy = 1'b1;
        tick;
        tx_busy = 1'b0;
        tick;
        chk("dropped_done", done_a, 4'b0001);
        m_owner = 0;
        wait_idle;

        req = 4'b0010; req_data = 16'h00A0;
        tick;
        chk("ena_gnt", gnt_a, 4'b0010);
        req = '0; tx_busy = 1'b1;
        tick;
        tick;
        ena = 1'b0; tx_busy = 1'b0; held = 1'b1;
        repeat (10) begin
            tick;
            held &= (st_a == 2'd2) && (done_a == 4'd0) && (txd_a == ham(4'hA));
        end
        chk("ena_hold", held, 1);
        ena = 1'b1;
        tick;
        chk("ena_done", done_a, 4'b0010);
        chk("ena_gap", st_a, 3);
        m_owner = 1;
        wait_idle;

        repeat (25) begin
            req_data = 16'($urandom);
            req = 4'($urandom_range(1, 15));
            serve(rr_pick(m_owner, req), 1'b0);
            wait_idle;
        end

        apply_reset;
        req = 4'b0100; req_data = 16'h0600;
        tick;
        chk("gap_gnt_bc", {gnt_b, gnt_c}, {4'b0100, 4'b0100});
        tx_busy = 1'b1;
        tick;
        tx_busy = 1'b0;
        tick;
        chk("gap_done", {done_a, done_b, done_c}, {4'b0100, 4'b0100, 4'b0100});
        ga = -1; gb = -1; gc = -1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (gnt_a != 4'd0 && ga < 0) ga = k;
            if (gnt_b != 4'd0 && gb < 0) gb = k;
            if (gnt_c != 4'd0 && gc < 0) gc = k;
        end
        chk("gap8_regnt", ga, 9);
        chk("gap3_regnt", gb, 4);
        chk("gap0_regnt", gc, 1);

        apply_reset;
        req = 4'b0010;
        tick;
        chk("rst_mid_gnt", gnt_a, 4'b0010);
        req = '0; tx_busy = 1'b1;
        tick;
        chk("rst_mid_send", st_a, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {st_a, own_a}, {2'd0, 3'd3});
        chk("rst_mid_out", {gnt_a, done_a, err_a, txs_a, txd_a}, 0);
        #1 rst_n = 1'b1;
        tx_busy = 1'b0; req = 4'hF;
        tick;
        chk("rst_mid_rr", gnt_a, 4'b0001);
        req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
